// File: rtl/led_pattern_scheduler.sv
// led_pattern_scheduler
//   Steps a 4-LED pattern (plus one status LED) once every TICK_DIV clock
//   cycles. Four patterns are available: binary COUNT, one-hot ROTATE,
//   BOUNCE and BLINK. Mode changes arrive via a valid/ready handshake. They
//   are held pending and take effect on the next step boundary. When a
//   change takes effect, the step counter restarts at 0.
//
// Ports
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   pause      : freezes the prescaler, so no ticks occur while high
//   mode_valid : a mode-change request is present
//   mode_req   : requested mode (0 COUNT, 1 ROTATE, 2 BOUNCE, 3 BLINK)
//   mode_ready : high when a request can be accepted (nothing pending)
//   mode_cur   : the active mode
//   tick       : one-cycle pulse on each step boundary
//   led        : led[4] is the status LED, led[3:0] are the pattern LEDs
module led_pattern_scheduler #(
    parameter int TICK_DIV = 12000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause,
    input  logic       mode_valid,
    input  logic [1:0] mode_req,
    output logic       mode_ready,
    output logic [1:0] mode_cur,
    output logic       tick,
    output logic [4:0] led
);

    localparam logic [23:0] DIV_LAST = 24'(TICK_DIV - 1);

    localparam logic [1:0] MODE_COUNT  = 2'd0;
    localparam logic [1:0] MODE_ROTATE = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_BLINK  = 2'd3;

    // RUN: nothing pending. PENDING: a request is latched and waits for a tick.
    typedef enum logic {
        RUN     = 1'b0,
        PENDING = 1'b1
    } state_t;

    state_t      state_reg, state_next;
    logic [23:0] div_reg, div_next;
    logic [3:0]  step_reg, step_next, step_adv;
    logic [1:0]  mode_reg, mode_next;
    logic [1:0]  pend_mode_reg, pend_mode_next;
    logic        accept;
    logic [3:0]  bounce_pos;

    // A tick is suppressed while paused or in reset.
    assign tick       = !rst && !pause && (div_reg == DIV_LAST);
    assign mode_ready = (state_reg == RUN);
    assign accept     = mode_valid && mode_ready;
    assign mode_cur   = mode_reg;

    // Next step value under the active mode, with a per-mode wrap point.
    always_comb begin
        step_adv = step_reg + 4'd1;
        case (mode_reg)
            MODE_COUNT:  step_adv = step_reg + 4'd1;
            MODE_ROTATE: step_adv = (step_reg == 4'd3) ? 4'd0 : step_reg + 4'd1;
            MODE_BOUNCE: step_adv = (step_reg == 4'd7) ? 4'd0 : step_reg + 4'd1;
            MODE_BLINK:  step_adv = {3'b000, ~step_reg[0]};
            default:     step_adv = 4'd0;
        endcase
    end

    // Next-state logic for the FSM, prescaler, step, mode and pending slot.
    always_comb begin
        state_next     = state_reg;
        div_next       = div_reg;
        step_next      = step_reg;
        mode_next      = mode_reg;
        pend_mode_next = pend_mode_reg;

        if (!pause) begin
            div_next = (div_reg == DIV_LAST) ? 24'd0 : div_reg + 24'd1;
        end

        case (state_reg)
            RUN: begin
                // If a request arrives on a tick, the tick still advances the
                // old mode. The new mode waits for the following tick.
                if (tick) begin
                    step_next = step_adv;
                end
                if (accept) begin
                    pend_mode_next = mode_req;
                    state_next     = PENDING;
                end
            end
            PENDING: begin
                if (tick) begin
                    mode_next  = pend_mode_reg;
                    step_next  = 4'd0;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= RUN;
            div_reg       <= 24'd0;
            step_reg      <= 4'd0;
            mode_reg      <= MODE_COUNT;
            pend_mode_reg <= MODE_COUNT;
        end else begin
            state_reg     <= state_next;
            div_reg       <= div_next;
            step_reg      <= step_next;
            mode_reg      <= mode_next;
            pend_mode_reg <= pend_mode_next;
        end
    end

    // BOUNCE walks the single lit LED up to led[4] and back down again.
    assign bounce_pos = (step_reg <= 4'd4) ? step_reg : (4'd8 - step_reg);

    // Decode the registered mode and step into LED drive.
    always_comb begin
        led = 5'b00000;
        case (mode_reg)
            MODE_COUNT:  led = {(step_reg < 4'd4), step_reg};
            MODE_ROTATE: led = {(step_reg[1:0] == 2'd3), 4'b0001 << step_reg[1:0]};
            MODE_BOUNCE: led = 5'b00001 << bounce_pos[2:0];
            MODE_BLINK:  led = (step_reg != 4'd0) ? 5'b11111 : 5'b00000;
            default:     led = 5'b00000;
        endcase
    end

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Testbench for led_pattern_scheduler (TICK_DIV = 4).
// The stimulus process drives inputs shortly after each rising edge. It then
// pushes the outputs expected for that cycle into a queue and advances a
// behavioural model for the coming edge. A monitor pops one entry at every
// falling edge and compares it against the DUT outputs.
module tb_led_pattern_scheduler;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       pause;
    logic       mode_valid;
    logic [1:0] mode_req;
    logic       mode_ready;
    logic [1:0] mode_cur;
    logic       tick;
    logic [4:0] led;

    led_pattern_scheduler #(.TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst        (rst),
        .pause      (pause),
        .mode_valid (mode_valid),
        .mode_req   (mode_req),
        .mode_ready (mode_ready),
        .mode_cur   (mode_cur),
        .tick       (tick),
        .led        (led)
    );

    always #5 clk = ~clk;

    // Expected outputs, packed as {mode_ready, mode_cur, tick, led}.
    logic [8:0] sb[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Behavioural model state.
    int m_mode, m_step, m_cnt, m_pmode;
    bit m_pend;
    bit last_accept;

    function automatic int pat_len(input int md);
        case (md)
            0:       return 16;
            1:       return 4;
            2:       return 8;
            default: return 2;
        endcase
    endfunction

    function automatic logic [4:0] exp_led(input int md, input int st);
        int pos;
        case (md)
            0: return 5'(((st < 4) ? 16 : 0) + st);
            1: return 5'((1 << st) + ((st == 3) ? 16 : 0));
            2: begin
                pos = (st <= 4) ? st : 8 - st;
                return 5'(1 << pos);
            end
            default: return (st != 0) ? 5'h1f : 5'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_step  = 0;
        m_cnt   = 0;
        m_pmode = 0;
        m_pend  = 0;
    endtask

    // One clock cycle: drive inputs, record the expected outputs, step the model.
    task automatic drive_cycle(input logic r, input logic p, input logic v, input logic [1:0] q);
        bit t;
        @(posedge clk);
        #1;
        rst        = r;
        pause      = p;
        mode_valid = v;
        mode_req   = q;
        cyc++;
        t = !r && !p && (m_cnt == TD - 1);
        sb.push_back({!m_pend, 2'(m_mode), t, exp_led(m_mode, m_step)});
        last_accept = !r && v && !m_pend;
        if (r) begin
            model_reset();
        end else begin
            if (t) begin
                if (m_pend) begin
                    m_mode = m_pmode;
                    m_step = 0;
                    m_pend = 0;
                end else begin
                    m_step = (m_step + 1) % pat_len(m_mode);
                end
            end
            if (last_accept) begin
                m_pend  = 1;
                m_pmode = int'(q);
                $display("cycle %0d: request mode %0d accepted (tick=%0d pause=%0d)", cyc, q, t, p);
            end
            if (!p) m_cnt = (m_cnt + 1) % TD;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic idle_until_cnt(input int c);
        int k = 0;
        while (m_cnt != c && k < 20) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 2'd0);
            k++;
        end
    endtask

    // Hold a request until the handshake completes, within a bounded wait.
    task automatic request(input logic [1:0] q);
        int k = 0;
        last_accept = 0;
        while (!last_accept && k < 50) begin
            drive_cycle(1'b0, 1'b0, 1'b1, q);
            k++;
        end
        checks++;
        if (!last_accept) begin
            errors++;
            $display("FAIL handshake_timeout mode=%0d: not accepted within %0d cycles, required accept", q, k);
        end
    endtask

    // Monitor: one comparison per cycle.
    initial begin
        logic [8:0] e, a;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = {mode_ready, mode_cur, tick, led};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got ready=%b mode=%0d tick=%b led=%b, required ready=%b mode=%0d tick=%b led=%b",
                             cyc, a[8], a[7:6], a[5], a[4:0], e[8], e[7:6], e[5], e[4:0]);
                end
            end
        end
    end

    initial begin
        bit         rv, pv, vv;
        logic [1:0] qv;

        rst = 1'b1; pause = 1'b0; mode_valid = 1'b0; mode_req = 2'd0;
        model_reset();
        last_accept = 0;
        repeat (2) @(posedge clk);
        // A request presented during reset must be discarded.
        drive_cycle(1'b1, 1'b0, 1'b1, 2'd3);

        // Free-running COUNT after reset release.
        idle(20);

        // ROTATE requested mid-period.
        idle_until_cnt(1);
        request(2'd1);
        idle(20);

        // BOUNCE requested in the tick cycle itself.
        idle_until_cnt(TD - 1);
        request(2'd2);
        idle(40);

        // BLINK requested while paused: accepted, then applied after release.
        drive_cycle(1'b0, 1'b1, 1'b1, 2'd3);
        for (int i = 0; i < 9; i++) drive_cycle(1'b0, 1'b1, 1'b0, 2'd0);
        idle(12);

        // Reset while a request is pending with the prescaler at 2.
        idle_until_cnt(0);
        request(2'd1);
        idle_until_cnt(2);
        drive_cycle(1'b1, 1'b0, 1'b0, 2'd0);
        idle(12);

        // Second request while pending, then a full COUNT wrap.
        request(2'd2);
        request(2'd0);
        idle(80);

        // Randomized traffic with occasional pause and reset.
        vv = 0; qv = 2'd0;
        for (int i = 0; i < 1500; i++) begin
            if (!(vv && !last_accept)) begin
                vv = ($urandom_range(0, 3) == 0);
                qv = 2'($urandom_range(0, 3));
            end
            pv = ($urandom_range(0, 4) == 0);
            rv = ($urandom_range(0, 99) == 0);
            drive_cycle(rv, pv, vv, qv);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
